// File: rtl/wlan_deinterleaver_pkg.sv
// Shared 802.11a deinterleaver definitions: modulation codes and per-modulation
// symbol sizes used by both the address generator and the bank control.
package wlan_pkg;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'b00,
        MOD_QPSK  = 2'b01,
        MOD_16QAM = 2'b10,
        MOD_64QAM = 2'b11
    } mod_e;

    localparam int unsigned MAX_NCBPS = 288;
    localparam int unsigned ADDR_W    = 9;

    localparam logic [ADDR_W-1:0] NCBPS_BPSK  = 9'd48;
    localparam logic [ADDR_W-1:0] NCBPS_QPSK  = 9'd96;
    localparam logic [ADDR_W-1:0] NCBPS_16QAM = 9'd192;
    localparam logic [ADDR_W-1:0] NCBPS_64QAM = 9'd288;

    localparam logic [ADDR_W-1:0] NBPSC_BPSK  = 9'd1;
    localparam logic [ADDR_W-1:0] NBPSC_QPSK  = 9'd2;
    localparam logic [ADDR_W-1:0] NBPSC_16QAM = 9'd4;
    localparam logic [ADDR_W-1:0] NBPSC_64QAM = 9'd6;

    function automatic logic [ADDR_W-1:0] ncbps_of(input mod_e m);
        case (m)
            MOD_BPSK:  return NCBPS_BPSK;
            MOD_QPSK:  return NCBPS_QPSK;
            MOD_16QAM: return NCBPS_16QAM;
            default:   return NCBPS_64QAM;
        endcase
    endfunction

endpackage

// File: rtl/wlan_deinterleaver_if.sv
// Serial bit-stream handshake interfaces for the deinterleaver input and output.
interface wlan_deint_in_if;
    import wlan_pkg::*;
    logic valid;
    logic ready;
    logic data;
    mod_e mod;

    modport master (output valid, data, mod, input ready);
    modport slave  (input valid, data, mod, output ready);
endinterface

interface wlan_deint_out_if;
    import wlan_pkg::*;
    logic valid;
    logic ready;
    logic data;
    logic last;
    mod_e mod;

    modport master (output valid, data, last, mod, input ready);
    modport slave  (input valid, data, last, mod, output ready);
endinterface

// File: rtl/wlan_deinterleaver_addr_gen.sv
// Receive-side permutation: received index j -> original coded index k.
module deint_addr_gen
    import wlan_pkg::*;
(
    input  logic [ADDR_W-1:0] j,
    input  mod_e              mod,
    output logic [ADDR_W-1:0] k
);

    logic [ADDR_W-1:0] q;
    logic [ADDR_W-1:0] t;
    logic [ADDR_W-1:0] i;

    // All terms wrap mod 512; true k < 288, so the truncated result is exact.
    always_comb begin
        q = '0;
        t = '0;
        i = '0;
        k = '0;
        case (mod)
            MOD_BPSK: begin
                i = j;
                k = (i << 4) - (NCBPS_BPSK - 9'd1) * (i / (9'd3 * NBPSC_BPSK));
            end
            MOD_QPSK: begin
                i = j;
                k = (i << 4) - (NCBPS_QPSK - 9'd1) * (i / (9'd3 * NBPSC_QPSK));
            end
            MOD_16QAM: begin
                q = j / (9'd3 * NBPSC_16QAM);
                t = j + q;
                i = {j[8:1], 1'b0} + {8'b0, t[0]};
                k = (i << 4) - (NCBPS_16QAM - 9'd1) * (i / (9'd3 * NBPSC_16QAM));
            end
            default: begin
                q = j / (9'd3 * NBPSC_64QAM);
                t = j + q;
                i = (j / 9'd3) * 9'd3 + (t % 9'd3);
                k = (i << 4) - (NCBPS_64QAM - 9'd1) * (i / (9'd3 * NBPSC_64QAM));
            end
        endcase
    end

endmodule

// File: rtl/wlan_deinterleaver.sv
// 802.11a block deinterleaver with two ping-pong symbol banks; bits are written
// at their permuted address and read out sequentially.
module wlan_deinterleaver
    import wlan_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    wlan_deint_in_if.slave    in_if,
    wlan_deint_out_if.master  out_if
);

    logic [MAX_NCBPS-1:0] bank [2];
    mod_e                 bank_mod [2];
    logic [1:0]           full;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [ADDR_W-1:0]    j_cnt;
    logic [ADDR_W-1:0]    r_cnt;
    logic                 started;
    logic                 hold_bit;
    logic                 hold_last;
    mod_e                 hold_mod;

    mod_e                 wr_mod;
    logic [ADDR_W-1:0]    k;
    logic [ADDR_W-1:0]    wr_n;
    logic [ADDR_W-1:0]    rd_n;
    logic                 in_fire;
    logic                 out_fire;
    logic                 wr_last;
    logic                 rd_last;

    always_comb begin
        wr_mod   = (j_cnt == '0) ? in_if.mod : bank_mod[wr_ptr];
        wr_n     = ncbps_of(wr_mod);
        rd_n     = ncbps_of(bank_mod[rd_ptr]);
        wr_last  = (j_cnt == wr_n - 9'd1);
        rd_last  = (r_cnt == rd_n - 9'd1);
        in_if.ready  = started & ~full[wr_ptr];
        out_if.valid = full[rd_ptr];
        in_fire  = in_if.valid & in_if.ready;
        out_fire = out_if.valid & out_if.ready;
    end

    // Outputs hold the last transferred values while no bank is ready.
    always_comb begin
        out_if.data = hold_bit;
        out_if.last = hold_last;
        out_if.mod  = hold_mod;
        if (out_if.valid) begin
            out_if.data = bank[rd_ptr][r_cnt];
            out_if.last = rd_last;
            out_if.mod  = bank_mod[rd_ptr];
        end
    end

    deint_addr_gen u_addr_gen (
        .j   (j_cnt),
        .mod (wr_mod),
        .k   (k)
    );

    always_ff @(posedge clk) begin
        if (in_fire) bank[wr_ptr][k] <= in_if.data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full        <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            j_cnt       <= '0;
            r_cnt       <= '0;
            started     <= 1'b0;
            hold_bit    <= 1'b0;
            hold_last   <= 1'b0;
            hold_mod    <= MOD_BPSK;
            bank_mod[0] <= MOD_BPSK;
            bank_mod[1] <= MOD_BPSK;
        end else begin
            started <= 1'b1;
            // Write and read banks always differ, so both full updates can land together.
            if (in_fire) begin
                if (j_cnt == '0) bank_mod[wr_ptr] <= in_if.mod;
                if (wr_last) begin
                    full[wr_ptr] <= 1'b1;
                    wr_ptr       <= ~wr_ptr;
                    j_cnt        <= '0;
                end else begin
                    j_cnt <= j_cnt + 9'd1;
                end
            end
            if (out_fire) begin
                hold_bit  <= out_if.data;
                hold_last <= out_if.last;
                hold_mod  <= out_if.mod;
                if (rd_last) begin
                    full[rd_ptr] <= 1'b0;
                    rd_ptr       <= ~rd_ptr;
                    r_cnt        <= '0;
                end else begin
                    r_cnt <= r_cnt + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wlan_deinterleaver.sv
// Scoreboard bench for wlan_deinterleaver: directed one-hot vectors, round trips
// through a transmit-interleaver model, backpressure and mid-symbol reset.
module tb_wlan_deinterleaver;
    import wlan_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wlan_deint_in_if  in_s ();
    wlan_deint_out_if out_s ();

    wlan_deinterleaver dut (
        .clk    (clk),
        .reset  (rst_n),
        .in_if  (in_s),
        .out_if (out_s)
    );

    typedef struct packed {
        logic b;
        logic last;
        mod_e mod;
    } exp_t;

    exp_t        sb [$];
    int unsigned checks    = 0;
    int unsigned passed    = 0;
    int unsigned accepted  = 0;
    int unsigned in_stalls = 0;
    int unsigned gaps      = 0;
    bit          abort     = 0;
    bit          gap_mon   = 0;
    bit          seen      = 0;
    bit          bp_done   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_s.valid && out_s.ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL out_unexpected: got bit=%0b last=%0b mod=%0d expected no output",
                         out_s.data, out_s.last, out_s.mod);
            end else begin
                e = sb.pop_front();
                chk("out_bit_last_mod", {28'b0, out_s.data, out_s.last, out_s.mod},
                    {28'b0, e.b, e.last, e.mod});
            end
            if (gap_mon) seen = 1;
        end else if (gap_mon && seen && sb.size() > 0) begin
            gaps++;
        end
    end

    function automatic int unsigned nbpsc_tb(input mod_e m);
        case (m)
            MOD_BPSK:  return 1;
            MOD_QPSK:  return 2;
            MOD_16QAM: return 4;
            default:   return 6;
        endcase
    endfunction

    // Transmit interleaver: original index k -> transmitted index j.
    function automatic int unsigned tx_j(input int unsigned k, input int unsigned n, input int unsigned nb);
        int unsigned s;
        int unsigned i;
        s = (nb / 2 < 1) ? 1 : nb / 2;
        i = (n / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + n - (16 * i) / n) % s;
    endfunction

    task automatic send_bit(input logic b, input mod_e m);
        int unsigned budget;
        if (abort) return;
        budget = 0;
        in_s.valid = 1'b1;
        in_s.data  = b;
        in_s.mod   = m;
        @(negedge clk);
        while (!in_s.ready) begin
            in_stalls++;
            budget++;
            if (budget > 2000) begin
                chk("in_ready_timeout", 32'd0, 32'd1);
                abort = 1;
                in_s.valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        accepted++;
        in_s.valid = 1'b0;
    endtask

    task automatic send_sym(input mod_e m, input logic [287:0] x, input logic [287:0] d,
                            input bit push, input int unsigned nbits);
        int unsigned n;
        n = 48 * nbpsc_tb(m);
        if (push)
            for (int unsigned k = 0; k < n; k++)
                sb.push_back('{b: d[k], last: (k == n - 1), mod: m});
        // in_mod after the first bit is deliberately wrong; the block must ignore it.
        for (int unsigned j = 0; j < nbits; j++)
            send_bit(x[j], (j == 0) ? m : mod_e'(~m));
    endtask

    task automatic onehot(input mod_e m, input int unsigned jpos, input int unsigned kexp);
        logic [287:0] x;
        logic [287:0] d;
        x = '0;
        d = '0;
        x[jpos] = 1'b1;
        d[kexp] = 1'b1;
        send_sym(m, x, d, 1, 48 * nbpsc_tb(m));
    endtask

    task automatic round_trip(input mod_e m, input bit push);
        logic [287:0] x;
        logic [287:0] d;
        int unsigned  nb;
        int unsigned  n;
        nb = nbpsc_tb(m);
        n  = 48 * nb;
        x = '0;
        d = '0;
        for (int unsigned k = 0; k < n; k++) d[k] = 1'($urandom_range(0, 1));
        for (int unsigned k = 0; k < n; k++) x[tx_j(k, n, nb)] = d[k];
        send_sym(m, x, d, push, n);
    endtask

    task automatic wait_drain();
        int unsigned budget;
        budget = 0;
        @(negedge clk);
        while (sb.size() != 0 || out_s.valid) begin
            budget++;
            if (budget > 5000) begin
                chk("drain_timeout", sb.size(), 32'd0);
                abort = 1;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned budget;
        logic [287:0] zeros;
        zeros = '0;
        in_s.valid  = 1'b0;
        in_s.data   = 1'b0;
        in_s.mod    = MOD_BPSK;
        out_s.ready = 1'b1;

        #12;
        chk("rst_in_ready",  {31'b0, in_s.ready},  32'd0);
        chk("rst_out_valid", {31'b0, out_s.valid}, 32'd0);
        chk("rst_out_bit",   {31'b0, out_s.data},  32'd0);
        chk("rst_out_last",  {31'b0, out_s.last},  32'd0);
        chk("rst_out_mod",   {30'b0, out_s.mod},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready_before_clk", {31'b0, in_s.ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("release_in_ready_after_clk", {31'b0, in_s.ready}, 32'd1);

        // Hand-computed one-hot vectors, all modulations.
        onehot(MOD_BPSK, 3, 1);
        onehot(MOD_BPSK, 1, 16);
        onehot(MOD_QPSK, 6, 1);
        onehot(MOD_QPSK, 1, 16);
        onehot(MOD_16QAM, 12, 17);
        onehot(MOD_16QAM, 13, 1);
        onehot(MOD_64QAM, 18, 17);
        onehot(MOD_64QAM, 1, 16);
        wait_drain();
        chk("idle_out_last_held", {31'b0, out_s.last}, 32'd1);
        chk("idle_out_valid", {31'b0, out_s.valid}, 32'd0);

        // Same-modulation streaming: no input stalls, no output gaps.
        gap_mon = 1; seen = 0; gaps = 0; in_stalls = 0;
        round_trip(MOD_16QAM, 1);
        round_trip(MOD_16QAM, 1);
        round_trip(MOD_16QAM, 1);
        wait_drain();
        gap_mon = 0;
        chk("stream_out_gaps", gaps, 32'd0);
        chk("stream_in_stalls", in_stalls, 32'd0);

        // Alternating modulations.
        round_trip(MOD_BPSK, 1);
        round_trip(MOD_64QAM, 1);
        round_trip(MOD_QPSK, 1);
        round_trip(MOD_16QAM, 1);
        round_trip(MOD_64QAM, 1);
        round_trip(MOD_BPSK, 1);
        wait_drain();

        // Backpressure with three BPSK symbols offered.
        out_s.ready = 1'b0;
        accepted = 0;
        bp_done = 0;
        fork
            begin
                round_trip(MOD_BPSK, 1);
                round_trip(MOD_BPSK, 1);
                round_trip(MOD_BPSK, 1);
                bp_done = 1;
            end
        join_none
        repeat (250) @(posedge clk);
        #1;
        chk("bp_accepted", accepted, 32'd96);
        chk("bp_in_ready", {31'b0, in_s.ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_s.valid}, 32'd1);
        out_s.ready = 1'b1;
        budget = 0;
        while (!bp_done && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        #1;
        chk("bp_sender_done", {31'b0, bp_done}, 32'd1);
        wait_drain();
        chk("bp_in_ready_back", {31'b0, in_s.ready}, 32'd1);

        // Reset with one full bank and a partial 16QAM symbol at j=20.
        out_s.ready = 1'b0;
        round_trip(MOD_BPSK, 0);
        send_sym(MOD_16QAM, zeros, zeros, 0, 20);
        chk("pre_reset_out_valid", {31'b0, out_s.valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", {31'b0, out_s.valid}, 32'd0);
        chk("mid_reset_in_ready",  {31'b0, in_s.ready},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_s.ready = 1'b1;
        @(posedge clk);
        #1;
        onehot(MOD_16QAM, 13, 1);
        onehot(MOD_16QAM, 12, 17);
        round_trip(MOD_64QAM, 1);
        wait_drain();
        chk("final_queue_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
